colour_blob_tracker: RTL and testbench
======================================

// Module: colour_blob_tracker
// PURPOSE
// Consumes the 320x240 RGB565 pixel stream produced by the OV7670 capture stage (TDATA/TVALID/FSYNC/EOL, READY back).
// Per frame it thresholds every pixel against a colour box, accumulates match count and X/Y coordinate sums,
// and then serially divides the sums to give the blob centroid. The game logic uses the centroid as the player position.
// PARAMETERS
// WIDTH     320  pixels per line; X counter range 0..WIDTH-1
// HEIGHT    240  lines per frame; Y counter range 0..HEIGHT-1
// XW        9    width of X counter and CX
// YW        8    width of Y counter and CY
// CW        17   width of match counter and COUNT
// SUM_W     25   width of SUM_X/SUM_Y accumulators and divider dividend
// R_MIN/R_MAX 5'd20/5'd31, G_MIN/G_MAX 6'd0/6'd20, B_MIN/B_MAX 5'd0/5'd10: inclusive colour box
// MIN_COUNT 64   FOUND asserts when COUNT >= MIN_COUNT
// PORTS
// FSM_CLK       in   1      sole clock
// RESETN        in   1      synchronous, active-low reset
// S_TDATA       in   32     pixel; RGB565 in [15:0] (R=[15:11] G=[10:5] B=[4:0]), [31:16] ignored
// S_TVALID      in   1      beat valid
// S_FSYNC       in   1      first pixel of frame (qualified by S_TVALID)
// S_EOL         in   1      last pixel of line (qualified by S_TVALID)
// S_READY       out  1      to capture READY; 1 whenever out of reset
// CX            out  XW     centroid X of last completed frame
// CY            out  YW     centroid Y of last completed frame
// COUNT         out  CW     matched pixels in last completed frame
// FOUND         out  1      COUNT >= MIN_COUNT
// RESULT_VALID  out  1      one-cycle pulse when CX/CY/COUNT/FOUND update
// FRAME_ERR     out  1      one-cycle pulse when a partial frame is discarded
// BEHAVIOUR
// - Reset (RESETN=0 at a FSM_CLK edge): all outputs 0, S_READY 0, counters/accumulators 0, state IDLE. Mid-frame reset discards all partial work.
// - A beat is accepted when S_TVALID=1 and S_READY=1; S_READY=1 in every state after reset (never backpressures).
// - Match = R,G,B each within its [MIN,MAX] box, all bounds inclusive.
// - States: IDLE -> ACCUM on an accepted beat with S_FSYNC=1. Non-FSYNC beats are ignored in IDLE.
// - ACCUM, on each accepted beat: a match does COUNT_acc+=1, SUM_X+=x, SUM_Y+=y. x+=1 saturates at WIDTH-1.
//   An S_EOL beat sets x=0 and y+=1.
//   The FSYNC beat itself is pixel (0,0): the accumulators are loaded with that pixel's contribution, not added to.
// - End of frame: an accepted S_EOL beat with y=HEIGHT-1.
//   Snapshot COUNT_acc/SUM_X/SUM_Y into the divider, clear the accumulators, then go to IDLE (wait for next FSYNC).
// - FSYNC seen in ACCUM (short frame): pulse FRAME_ERR, discard the partial frame, start a new frame with that beat as (0,0).
//   No RESULT_VALID is produced for the discarded frame.
// - Divider: one shared restoring divider, 1 quotient bit per cycle.
//   DIV_X takes SUM_W cycles (SUM_X/COUNT), then DIV_Y takes SUM_W cycles (SUM_Y/COUNT).
//   It runs independently of the stream FSM, so accumulation of the next frame proceeds concurrently.
// - COUNT=0: the divider still runs, quotients are forced to 0, FOUND=0. Latency is identical.
// - Latency: RESULT_VALID pulses exactly 2*SUM_W+2 cycles after the end-of-frame beat.
//   CX/CY/COUNT/FOUND update in that same cycle and hold until the next update.
//   Quotients are truncated (floor); CX=quotient[XW-1:0], CY=quotient[YW-1:0].
// - End-of-frame while the divider is busy: the new snapshot is dropped and FRAME_ERR pulses.
//   This is unreachable at nominal rates but is defined.
// - End-of-frame coinciding with FSYNC on the same beat: treat it as end-of-frame; the next FSYNC starts the next frame.
// - All arithmetic is unsigned. Sums cannot overflow at the default parameters (max 319*76800 < 2^25).
// TESTING (WIDTH=8, HEIGHT=4, SUM_W=12, MIN_COUNT=2 unless noted)
// 1 Reset: hold RESETN=0 for 3 cycles, drive beats -> all outputs 0, S_READY=0. Release -> S_READY=1 next cycle.
// 2 Single frame, matches at (2,1) and (6,3) (pixel 16'hF800), rest 0 ->
//   RESULT_VALID 26 cycles after the last EOL beat; CX=4, CY=2, COUNT=2, FOUND=1.
// 3 Frame with no matching pixels -> RESULT_VALID at the same 26-cycle latency; CX=0, CY=0, COUNT=0, FOUND=0.
// 4 FSYNC mid-frame at y=2, then a full frame whose only match is at (7,0) ->
//   FRAME_ERR pulses once at the early FSYNC; one RESULT_VALID with CX=7, CY=0, COUNT=1, FOUND=0.
// 5 Colour bounds: pixels with R=R_MIN, R=R_MAX, R=R_MIN-1 and G=G_MAX+1 -> COUNT=2 (only the in-bound pixels counted).
// 6 Gaps: random S_TVALID deassertion (50%) plus back-to-back frames ->
//   results match a reference model; reset mid-frame produces no RESULT_VALID for that frame.

Source files
------------

// File: rtl/colour_blob_tracker.sv
// colour_blob_tracker: thresholds an RGB565 frame stream against a colour box and
// reports the centroid of the matching pixels through a shared serial divider.
module colour_blob_tracker #(
    parameter int WIDTH = 320,
    parameter int HEIGHT = 240,
    parameter int XW = 9,
    parameter int YW = 8,
    parameter int CW = 17,
    parameter int SUM_W = 25,
    parameter logic [4:0] R_MIN = 5'd20,
    parameter logic [4:0] R_MAX = 5'd31,
    parameter logic [5:0] G_MIN = 6'd0,
    parameter logic [5:0] G_MAX = 6'd20,
    parameter logic [4:0] B_MIN = 5'd0,
    parameter logic [4:0] B_MAX = 5'd10,
    parameter int MIN_COUNT = 64
) (
    input  logic          FSM_CLK,
    input  logic          RESETN,
    input  logic [31:0]   S_TDATA,
    input  logic          S_TVALID,
    input  logic          S_FSYNC,
    input  logic          S_EOL,
    output logic          S_READY,
    output logic [XW-1:0] CX,
    output logic [YW-1:0] CY,
    output logic [CW-1:0] COUNT,
    output logic          FOUND,
    output logic          RESULT_VALID,
    output logic          FRAME_ERR
);
    localparam logic [0:0] IDLE = 1'b0, ACCUM = 1'b1;
    localparam int KW = $clog2(2 * SUM_W + 2);
    localparam int DW = (SUM_W > CW ? SUM_W : CW) + 1;
    localparam logic [KW-1:0] K_XE = KW'(SUM_W - 1);
    localparam logic [KW-1:0] K_IT = KW'(2 * SUM_W);
    localparam logic [KW-1:0] K_END = KW'(2 * SUM_W + 1);

    logic [0:0] state_q, state_d;
    logic ready_q;
    logic [XW-1:0] x_q, x_d, qx_q, qx_d, cx_q, cx_d;
    logic [YW-1:0] y_q, y_d, cy_q, cy_d;
    logic [CW-1:0] cnt_q, cnt_d, dvs_q, dvs_d, count_q, count_d, cnt_add;
    logic [SUM_W-1:0] sx_q, sx_d, sy_q, sy_d, sx_add, sy_add;
    logic [SUM_W-1:0] rem_q, rem_d, quo_q, quo_d, syh_q, syh_d, nq;
    logic [KW-1:0] k_q, k_d;
    logic busy_q, busy_d, found_q, found_d, rv_q, rv_d, err_q, err_d;
    logic acc, m, eof, start, fire, ge;
    logic [DW-1:0] sh, dv;
    logic unused_hi;

    function automatic logic in_box(input logic [5:0] v, input logic [5:0] lo, input logic [5:0] hi);
        logic [6:0] d;
        d = {1'b0, v} - {1'b0, lo};
        return d <= ({1'b0, hi} - {1'b0, lo});
    endfunction

    assign unused_hi = ^S_TDATA[31:16];
    assign acc = S_TVALID & ready_q;
    assign m = in_box({1'b0, S_TDATA[15:11]}, {1'b0, R_MIN}, {1'b0, R_MAX})
             & in_box(S_TDATA[10:5], G_MIN, G_MAX)
             & in_box({1'b0, S_TDATA[4:0]}, {1'b0, B_MIN}, {1'b0, B_MAX});
    // end-of-frame wins over a coincident FSYNC
    assign eof = acc & S_EOL & (state_q == ACCUM) & (y_q == YW'(HEIGHT - 1));
    assign start = acc & S_FSYNC & ~eof;
    assign cnt_add = cnt_q + CW'(m);
    assign sx_add = sx_q + (m ? SUM_W'(x_q) : '0);
    assign sy_add = sy_q + (m ? SUM_W'(y_q) : '0);

    always_comb begin
        state_d = state_q;
        x_d = x_q;
        y_d = y_q;
        cnt_d = cnt_q;
        sx_d = sx_q;
        sy_d = sy_q;
        err_d = 1'b0;
        fire = 1'b0;
        if (eof) begin
            fire = ~busy_q;
            err_d = busy_q;
            state_d = IDLE;
            x_d = '0;
            y_d = '0;
            cnt_d = '0;
            sx_d = '0;
            sy_d = '0;
        end else if (start) begin
            err_d = (state_q == ACCUM);
            state_d = ACCUM;
            cnt_d = CW'(m);
            sx_d = '0;
            sy_d = '0;
            x_d = S_EOL ? '0 : XW'(1);
            y_d = YW'(S_EOL);
        end else if (acc && state_q == ACCUM) begin
            cnt_d = cnt_add;
            sx_d = sx_add;
            sy_d = sy_add;
            x_d = S_EOL ? '0 : (x_q == XW'(WIDTH - 1) ? x_q : x_q + XW'(1));
            y_d = S_EOL ? y_q + YW'(1) : y_q;
        end
    end

    // restoring divider: dividend shifts out of quo_q while quotient bits shift in
    assign sh = DW'({rem_q, quo_q[SUM_W-1]});
    assign dv = DW'(dvs_q);
    assign ge = sh >= dv;
    assign nq = {quo_q[SUM_W-2:0], ge};

    always_comb begin
        busy_d = busy_q;
        k_d = k_q;
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        syh_d = syh_q;
        qx_d = qx_q;
        cx_d = cx_q;
        cy_d = cy_q;
        count_d = count_q;
        found_d = found_q;
        rv_d = 1'b0;
        if (fire) begin
            busy_d = 1'b1;
            k_d = '0;
            rem_d = '0;
            quo_d = sx_add;
            syh_d = sy_add;
            dvs_d = cnt_add;
        end else if (busy_q) begin
            k_d = k_q + KW'(1);
            if (k_q < K_IT) begin
                rem_d = ge ? SUM_W'(sh - dv) : SUM_W'(sh);
                quo_d = nq;
            end
            if (k_q == K_XE) begin
                qx_d = nq[XW-1:0];
                quo_d = syh_q;
                rem_d = '0;
            end
            if (k_q == K_END) begin
                busy_d = 1'b0;
                rv_d = 1'b1;
                cx_d = (dvs_q == '0) ? '0 : qx_q;
                cy_d = (dvs_q == '0) ? '0 : quo_q[YW-1:0];
                count_d = dvs_q;
                found_d = dvs_q >= CW'(MIN_COUNT);
            end
        end
    end

    always_ff @(posedge FSM_CLK) begin
        if (!RESETN) begin
            state_q <= IDLE;
            ready_q <= 1'b0;
            x_q <= '0;
            y_q <= '0;
            cnt_q <= '0;
            sx_q <= '0;
            sy_q <= '0;
            busy_q <= 1'b0;
            k_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
            dvs_q <= '0;
            syh_q <= '0;
            qx_q <= '0;
            cx_q <= '0;
            cy_q <= '0;
            count_q <= '0;
            found_q <= 1'b0;
            rv_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= 1'b1;
            x_q <= x_d;
            y_q <= y_d;
            cnt_q <= cnt_d;
            sx_q <= sx_d;
            sy_q <= sy_d;
            busy_q <= busy_d;
            k_q <= k_d;
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            syh_q <= syh_d;
            qx_q <= qx_d;
            cx_q <= cx_d;
            cy_q <= cy_d;
            count_q <= count_d;
            found_q <= found_d;
            rv_q <= rv_d;
            err_q <= err_d;
        end
    end

    assign S_READY = ready_q;
    assign CX = cx_q;
    assign CY = cy_q;
    assign COUNT = count_q;
    assign FOUND = found_q;
    assign RESULT_VALID = rv_q;
    assign FRAME_ERR = err_q;
endmodule

// File: tb/tb_colour_blob_tracker.sv
// tb_colour_blob_tracker: frame-level reference model feeding a result scoreboard.
module tb_colour_blob_tracker;
    localparam int W = 8, H = 4, XW = 4, YW = 3, CW = 6, SW = 12, LAT = 2 * SW + 2;

    logic clk = 1'b0, rstn = 1'b0;
    logic [31:0] tdata = '0;
    logic tvalid = 1'b0, fsync = 1'b0, eol = 1'b0;
    logic ready, found, rv, ferr;
    logic [XW-1:0] cx;
    logic [YW-1:0] cy;
    logic [CW-1:0] count;

    colour_blob_tracker #(
        .WIDTH(W), .HEIGHT(H), .XW(XW), .YW(YW), .CW(CW), .SUM_W(SW), .MIN_COUNT(2)
    ) dut (
        .FSM_CLK(clk), .RESETN(rstn), .S_TDATA(tdata), .S_TVALID(tvalid),
        .S_FSYNC(fsync), .S_EOL(eol), .S_READY(ready), .CX(cx), .CY(cy),
        .COUNT(count), .FOUND(found), .RESULT_VALID(rv), .FRAME_ERR(ferr)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0, fails = 0, err_seen = 0;
    typedef struct {int cx; int cy; int cnt; int found; int t;} exp_t;
    exp_t sb[$];
    logic [31:0] frame [0:W*H-1];

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit is_match(input logic [15:0] p);
        int r, g, b;
        r = int'(p[15:11]);
        g = int'(p[10:5]);
        b = int'(p[4:0]);
        return r >= 20 && r <= 31 && g >= 0 && g <= 20 && b >= 0 && b <= 10;
    endfunction

    task automatic beat(input logic [31:0] d, input logic fs, input logic el, input bit gaps);
        while (gaps && $urandom_range(0, 1) == 0) begin
            tvalid = 1'b0;
            @(posedge clk);
            #1;
        end
        tdata = d;
        fsync = fs;
        eol = el;
        tvalid = 1'b1;
        @(posedge clk);
        #1;
        tvalid = 1'b0;
        fsync = 1'b0;
        eol = 1'b0;
    endtask

    task automatic send_frame(input int rows, input bit gaps);
        int n, sx, sy;
        exp_t e;
        for (int y = 0; y < rows; y++)
            for (int x = 0; x < W; x++)
                beat(frame[y*W+x], x == 0 && y == 0, x == W - 1, gaps);
        if (rows == H) begin
            n = 0;
            sx = 0;
            sy = 0;
            for (int i = 0; i < W * H; i++)
                if (is_match(frame[i][15:0])) begin
                    n++;
                    sx += i % W;
                    sy += i / W;
                end
            e.cx = n != 0 ? sx / n : 0;
            e.cy = n != 0 ? sy / n : 0;
            e.cnt = n;
            e.found = n >= 2 ? 1 : 0;
            e.t = cyc;
            sb.push_back(e);
        end
    endtask

    task automatic clear_frame();
        for (int i = 0; i < W * H; i++) frame[i] = '0;
    endtask

    task automatic rand_frame();
        int dens;
        logic [4:0] r, b;
        logic [5:0] g;
        dens = $urandom_range(0, 3);
        for (int i = 0; i < W * H; i++) begin
            if ($urandom_range(0, 9) < dens) begin
                r = 5'($urandom_range(18, 31));
                g = 6'($urandom_range(0, 22));
                b = 5'($urandom_range(0, 12));
                frame[i] = {16'($urandom), r, g, b};
            end else frame[i] = $urandom;
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && sb.size() != 0; i++) @(posedge clk);
        #1;
        chk("results_drained", sb.size(), 0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (ferr) err_seen++;
        if (rv) begin
            if (sb.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_result: got RESULT_VALID with CX=%0d COUNT=%0d, expected none", cx, count);
            end else begin
                e = sb.pop_front();
                chk("cx", int'(cx), e.cx);
                chk("cy", int'(cy), e.cy);
                chk("count", int'(count), e.cnt);
                chk("found", int'(found), e.found);
                chk("latency", cyc - e.t, LAT);
            end
        end
    end

    initial begin
        // reset held while beats are offered
        for (int i = 0; i < 3; i++) begin
            beat(32'h0000F800, 1'b1, 1'b1, 1'b0);
            chk("reset_ready", int'(ready), 0);
            chk("reset_outputs", int'({cx, cy, count, found, rv, ferr}), 0);
        end
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_reset", int'(ready), 1);

        clear_frame();
        frame[1*W+2] = 32'h0000F800;
        frame[3*W+6] = 32'h0000F800;
        send_frame(H, 1'b0);
        drain();

        clear_frame();
        send_frame(H, 1'b0);
        drain();

        clear_frame();
        send_frame(2, 1'b0);
        frame[7] = 32'h0000F800;
        send_frame(H, 1'b0);
        drain();
        chk("frame_err_short", err_seen, 1);

        clear_frame();
        frame[0] = 32'h0000A000;
        frame[1] = 32'h0000F800;
        frame[2] = 32'h00009800;
        frame[3] = 32'h0000A2A0;
        frame[4] = 32'h0000A00B;
        frame[5] = 32'h0000A00A;
        send_frame(H, 1'b0);
        drain();

        for (int f = 0; f < 8; f++) begin
            rand_frame();
            send_frame(H, 1'b1);
        end
        drain();

        rand_frame();
        send_frame(2, 1'b1);
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("midreset_count", int'(count), 0);
        rstn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rand_frame();
        send_frame(H, 1'b1);
        drain();
        repeat (LAT + 5) @(posedge clk);
        #1;
        chk("frame_err_total", err_seen, 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
